// File: rtl/adder_pkg.sv
// Shared word type, arithmetic constants and the signed-overflow rule for the adder core.
// Pure declarations: no latency, no flow control.
package adder_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef logic signed [WIDTH_DEFAULT-1:0] word_t;

    localparam word_t WORD_MAX = 16'sd32767;
    localparam word_t WORD_MIN = -16'sd32768;
    localparam word_t WORD_ONE = 16'sd1;

    // Overflow only when both operands share a sign and the result sign flips.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder16_unit_if.sv
// Operand/result bundle of the adder core; master drives operands, slave returns results.
// Latency set by the attached core; no backpressure (in_valid is a capture strobe).
interface adder16_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] inc;
    logic             carry_out;
    logic             overflow;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             overflow_q;
    logic             out_valid;

    modport master (
        output a, b, in_valid,
        input  sum, inc, carry_out, overflow, sum_q, carry_q, overflow_q, out_valid
    );

    modport slave (
        input  a, b, in_valid,
        output sum, inc, carry_out, overflow, sum_q, carry_q, overflow_q, out_valid
    );
endinterface

// File: rtl/adder16_unit_ripple_add.sv
// Bit cells (half/full adder) and the ripple-carry chain built from them.
// Purely combinational, zero latency, no flow control.
module ha_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    ha_cell u_ha_ab (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    ha_cell u_ha_sc (
        .i_a     (w_s1),
        .i_b     (i_c),
        .o_sum   (o_sum),
        .o_carry (w_c2)
    );

    assign o_carry = w_c1 | w_c2;
endmodule

module ripple_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    logic [WIDTH-1:0] w_c;

    // Bit 0 has no carry-in, so a half adder is enough there.
    ha_cell u_bit0 (
        .i_a     (i_a[0]),
        .i_b     (i_b[0]),
        .o_sum   (o_sum[0]),
        .o_carry (w_c[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        fa_cell u_fa (
            .i_a     (i_a[i]),
            .i_b     (i_b[i]),
            .i_c     (w_c[i-1]),
            .o_sum   (o_sum[i]),
            .o_carry (w_c[i])
        );
    end

    assign o_carry = w_c[WIDTH-1];
endmodule

// File: rtl/adder16_unit.sv
// Adder core: standalone bit cells, comb a+b and a+1 ripple chains, one-cycle result register.
// Comb outputs zero latency, sum_q one cycle after in_valid; no backpressure.
module adder16_unit
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ha_a,
    input  logic ha_b,
    output logic ha_sum,
    output logic ha_carry,
    input  logic fa_a,
    input  logic fa_b,
    input  logic fa_c,
    output logic fa_sum,
    output logic fa_carry,
    adder16_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(WORD_ONE);

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic             w_inc_carry_unused;

    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic             r_overflow_q;
    logic             r_out_valid;

    ha_cell u_ha (
        .i_a     (ha_a),
        .i_b     (ha_b),
        .o_sum   (ha_sum),
        .o_carry (ha_carry)
    );

    fa_cell u_fa (
        .i_a     (fa_a),
        .i_b     (fa_b),
        .i_c     (fa_c),
        .o_sum   (fa_sum),
        .o_carry (fa_carry)
    );

    ripple_add #(.WIDTH(WIDTH)) u_add (
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Increment carry has no consumer; a+1 wraps silently.
    ripple_add #(.WIDTH(WIDTH)) u_inc (
        .i_a     (bus.a),
        .i_b     (ONE),
        .o_sum   (bus.inc),
        .o_carry (w_inc_carry_unused)
    );

    assign w_ovf = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], w_sum[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum_q      <= '0;
            r_carry_q    <= 1'b0;
            r_overflow_q <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum_q      <= w_sum;
                r_carry_q    <= w_carry;
                r_overflow_q <= w_ovf;
            end
        end
    end

    assign bus.sum        = w_sum;
    assign bus.carry_out  = w_carry;
    assign bus.overflow   = w_ovf;
    assign bus.sum_q      = r_sum_q;
    assign bus.carry_q    = r_carry_q;
    assign bus.overflow_q = r_overflow_q;
    assign bus.out_valid  = r_out_valid;
endmodule

// File: tb/tb_adder16_unit.sv
// Scoreboarded bench for adder16_unit: random and directed operands against an integer model.
module tb_adder16_unit;
    import adder_pkg::*;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ha_a, ha_b, ha_sum, ha_carry;
    logic fa_a, fa_b, fa_c, fa_sum, fa_carry;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];

    adder16_unit_if #(.WIDTH(16)) bus ();

    adder16_unit #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ha_a     (ha_a),
        .ha_b     (ha_b),
        .ha_sum   (ha_sum),
        .ha_carry (ha_carry),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_c     (fa_c),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed boundary / ripple / mixed-sign cases with hand-derived results.
    logic [15:0] t_a [0:14] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
                                16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'hAAAA,
                                16'h5555, 16'h7530, 16'h7FFF, 16'h8000, 16'h0002};
    logic [15:0] t_b [0:14] = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000,
                                16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h5555,
                                16'h5555, 16'hFFFF, 16'hFF9C, 16'h0064, 16'h0002};
    logic [15:0] t_s [0:14] = '{16'h8000, 16'hFFFE, 16'hFFFF, 16'h7FFF, 16'h0000,
                                16'h0010, 16'h0100, 16'h1000, 16'h0000, 16'hFFFF,
                                16'hAAAA, 16'h752F, 16'h7F9B, 16'h8064, 16'h0004};
    logic        t_c [0:14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        t_v [0:14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int unsigned u;
        int si;
        u   = int'(x) + int'(y);
        si  = int'($signed(x)) + int'($signed(y));
        e.s = u[15:0];
        e.c = (u > 32'd65535);
        e.v = (si > int'(WORD_MAX)) || (si < int'(WORD_MIN));
        return e;
    endfunction

    task automatic send(input logic [15:0] x, input logic [15:0] y, input bit vld);
        exp_t e;
        logic [15:0] ei;
        @(posedge clk);
        #1;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = vld;
        e  = model(x, y);
        ei = x + 16'd1;
        if (vld) q.push_back(e);
        #2;
        chk("sum",       bus.sum,       e.s);
        chk("inc",       bus.inc,       ei);
        chk("carry_out", bus.carry_out, e.c);
        chk("overflow",  bus.overflow,  e.v);
    endtask

    // Monitor: every presented registered result must match the oldest issued request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got sum_q %h, expected no result", bus.sum_q);
                end else begin
                    e = q.pop_front();
                    chk("sum_q",      bus.sum_q,      e.s);
                    chk("carry_q",    bus.carry_q,    e.c);
                    chk("overflow_q", bus.overflow_q, e.v);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] x, y, z, s1, s2;
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.in_valid = 1'b0;
        {ha_a, ha_b, fa_a, fa_b, fa_c} = '0;

        for (int i = 0; i < 4; i++) begin
            {ha_a, ha_b} = 2'(i);
            #1;
            chk("ha_sum",   ha_sum,   ha_a ^ ha_b);
            chk("ha_carry", ha_carry, ha_a & ha_b);
        end
        for (int i = 0; i < 8; i++) begin
            int cnt;
            {fa_a, fa_b, fa_c} = 3'(i);
            cnt = int'(fa_a) + int'(fa_b) + int'(fa_c);
            #1;
            chk("fa_sum",   fa_sum,   cnt % 2);
            chk("fa_carry", fa_carry, cnt >= 2);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sum_q",     bus.sum_q,      0);
        chk("rst_carry_q",   bus.carry_q,    0);
        chk("rst_ovf_q",     bus.overflow_q, 0);
        chk("rst_out_valid", bus.out_valid,  0);
        rst_n = 1'b1;

        // 2+2, then hold, then reset colliding with in_valid.
        send(16'd2, 16'd2, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 16'd7;
        bus.b = 16'd7;
        @(posedge clk);
        @(negedge clk);
        chk("hold_sum_q",     bus.sum_q,     16'd4);
        chk("hold_out_valid", bus.out_valid, 0);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'd9;
        bus.b = 16'd9;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_sum_q",     bus.sum_q,     0);
        chk("midrst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        send(16'd3, 16'd4, 1'b1);

        for (int i = 0; i < 15; i++) begin
            send(t_a[i], t_b[i], 1'b1);
            chk("tbl_sum",   bus.sum,       t_s[i]);
            chk("tbl_carry", bus.carry_out, t_c[i]);
            chk("tbl_ovf",   bus.overflow,  t_v[i]);
        end

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            z = 16'($urandom);
            send(x, y, 1'b1);
            send(y, x, 1'b1);
            send(x, 16'd0, 1'b1);
            send(x, -x, 1'b1);
            send(x, ~x + 16'd1, 1'b1);
            s1 = model(x, y).s;
            send(s1, z, 1'b1);
            s2 = model(y, z).s;
            send(s2, x, 1'b1);
            if ($urandom_range(0, 7) == 0) send(z, x, 1'b0);
        end

        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder16_unit.md
Name: adder16_unit

Overview:
- 16-bit two's-complement ripple-carry adder datapath built from half-adder and full-adder bit cells.
- Exposes:
  - standalone 1-bit half-adder and full-adder results;
  - a combinational 16-bit sum and increment;
  - a one-cycle registered copy of the sum.
- Used as the ALU/PC-increment arithmetic core of the CPU.

Parameters:
- WIDTH, 16, operand/result width in bits; only 16 is verified.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ha_a  in  1  half-adder operand a.
- ha_b  in  1  half-adder operand b.
- ha_sum  out  1  ha_a XOR ha_b.
- ha_carry  out  1  ha_a AND ha_b.
- fa_a  in  1  full-adder operand a.
- fa_b  in  1  full-adder operand b.
- fa_c  in  1  full-adder carry-in.
- fa_sum  out  1  a XOR b XOR c.
- fa_carry  out  1  majority(a, b, c).
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- in_valid  in  1  capture request for the registered result.
- sum  out  WIDTH  combinational (a+b) mod 2^WIDTH.
- inc  out  WIDTH  combinational (a+1) mod 2^WIDTH.
- carry_out  out  1  unsigned carry out of bit WIDTH-1 of a+b.
- overflow  out  1  signed overflow of a+b: operand signs equal and sum sign differs.
- sum_q  out  WIDTH  registered sum.
- carry_q  out  1  registered carry_out.
- overflow_q  out  1  registered overflow.
- out_valid  out  1  registered in_valid.

Behaviour:
- Half adder and full adder are purely combinational, zero latency, and independent of clk/rst_n.
- Adder structure:
  - sum is a ripple chain: bit 0 uses a half adder (carry-in 0); bits 1..WIDTH-1 use full adders.
  - Final carry drives carry_out.
  - Behavioural "+" is not used for the chain.
- inc uses the same chain structure with b = 1.
  - Either a second chain instance, or a half-adder chain propagating a constant 1 into bit 0.
- Arithmetic wraps modulo 2^16, with no saturation:
  - 0x7FFF+1 = 0x8000;
  - 0xFFFF+1 = 0x0000;
  - 0x8000+0x8000 = 0x0000 with carry_out = 1 and overflow = 1.
- The result is sign-agnostic: the same bits result for signed and unsigned interpretation.
- Combinational outputs settle within one clock period; there is no pipeline inside the comb path.
- Registered path, on each rising edge:
  - rst_n = 0: sum_q, carry_q, overflow_q and out_valid all become 0.
  - rst_n = 1 and in_valid = 1: capture sum, carry_out and overflow; out_valid is set to 1.
  - rst_n = 1 and in_valid = 0: hold the registered values; out_valid is set to 0.
- Latency: a result is visible on sum_q one cycle after in_valid is sampled high.
- Back-to-back in_valid: every cycle captures, giving throughput of 1 per clock.
- Reset asserted mid-stream overrides in_valid in the same cycle; the next valid result appears one cycle after the first in_valid sampled with rst_n = 1.
- No X propagation: all outputs are defined whenever the inputs are defined.

Decomposition:
- Package adder_pkg:
  - WIDTH_DEFAULT = 16;
  - word typedef (signed [15:0]);
  - constants WORD_MAX = 16'sd32767, WORD_MIN = -16'sd32768, WORD_ONE = 16'sd1.
- Sub-modules:
  - ha_cell (half adder) and fa_cell (full adder built from two ha_cell instances plus an OR).
  - One sub-module, ripple_add (WIDTH-bit chain producing sum and carry_out), instantiated twice: once for a+b and once for a+1.
- The register stage lives in the top, adder16_unit.

Test Plan:
- Exhaustive 1-bit cells:
  - all 4 ha inputs -> (0,0)=0/0, (0,1)=1/0, (1,0)=1/0, (1,1)=0/1;
  - all 8 fa inputs -> 111 gives sum 1 carry 1, 011 gives sum 0 carry 1.
- Algebraic properties on 1000 random a, b, c:
  - a+b == b+a;
  - (a+b)+c == (b+c)+a;
  - a+0 == a;
  - a+(-a) == 0;
  - a+(~a+1) == 0;
  - inc == a+1.
- Boundaries:
  - 32767+1 = -32768 (overflow = 1);
  - 32767+32767 = -2;
  - 32767+(-32768) = -1;
  - -32768+(-1) = 32767;
  - -32768+(-32768) = 0 with carry_out = 1.
- Carry ripple:
  - 0x000F+1 = 0x0010;
  - 0x00FF+1 = 0x0100;
  - 0x0FFF+1 = 0x1000;
  - 0xFFFF+1 = 0x0000 with carry_out = 1;
  - 0xAAAA+0x5555 = 0xFFFF;
  - 0x5555+0x5555 = 0xAAAA.
- Mixed sign:
  - 30000+(-1) = 29999;
  - 32767+(-100) = 32667;
  - -32768+100 = -32668;
  - 2+2 = 4.
- Register path:
  - hold rst_n low for 2 cycles -> sum_q = 0 and out_valid = 0.
  - release rst_n, apply a=2, b=2, in_valid=1 -> next edge gives sum_q = 4, out_valid = 1.
  - then in_valid = 0 -> sum_q holds 4, out_valid = 0.
  - assert rst_n = 0 together with in_valid = 1 -> sum_q = 0 on that edge.
